// File: rtl/ram_wait_param.sv
// rtl/ram_wait_param.sv - clocked big-endian byte-addressed RAM with MOV/MOC handshake and wait states
//
// Purpose: byte/halfword/word RAM for the ARM data path. A request is captured
// on MOV, held for WAIT_STATES cycles, performed, then reported with MOC until
// the control unit drops MOV. Misaligned or size==11 requests complete with
// fault=1 and touch neither memory nor DataOut.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   MOV       memory operation valid (held until MOC)
//   R_W       1 = read, 0 = write
//   size      00 byte, 01 halfword, 10 word, 11 illegal
//   sign_ext  reads: sign-extend byte/halfword
//   Address   byte address, lowest address holds the most significant byte
//   DataIn    write data (byte [7:0], halfword [15:0], word [31:0])
//   DataOut   registered read data
//   MOC       registered memory operation complete
//   fault     registered fault flag, qualified by MOC

module ram_wait_param #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MOV,
  input  logic              R_W,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MOC,
  output logic              fault
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              rw_q;
  logic              sext_q;
  logic [31:0]       din_q;
  logic [31:0]       dout_q;
  logic              moc_q;
  logic              fault_q;

  logic [7:0] mem [0:DEPTH-1];

  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [7:0]        b0, b1, b2, b3;
  logic              legal;
  logic [31:0]       rdata;
  logic              access_fire;

  // Consecutive byte addresses of the access; only the ones the size needs are used.
  assign a0 = addr_q;
  assign a1 = addr_q + ADDR_W'(1);
  assign a2 = addr_q + ADDR_W'(2);
  assign a3 = addr_q + ADDR_W'(3);

  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  // The access happens on the edge that leaves BUSY with the counter exhausted.
  assign access_fire = (state_q == S_BUSY) && (cnt_q == 4'd0);

  always_comb begin
    legal = 1'b0;
    rdata = 32'd0;
    case (size_q)
      2'b00: begin
        legal = 1'b1;
        rdata = {{24{sext_q & b0[7]}}, b0};
      end
      2'b01: begin
        legal = ~addr_q[0];
        rdata = {{16{sext_q & b0[7]}}, b0, b1};
      end
      2'b10: begin
        legal = (addr_q[1:0] == 2'b00);
        rdata = {b0, b1, b2, b3};
      end
      default: begin
        legal = 1'b0;
        rdata = 32'd0;
      end
    endcase
  end

  // Storage is deliberately not reset; a reset during BUSY leaves the FSM in
  // IDLE so access_fire cannot occur and a pending write is abandoned.
  always_ff @(posedge clk) begin
    if (access_fire && !rw_q && legal) begin
      case (size_q)
        2'b00: mem[a0] <= din_q[7:0];
        2'b01: begin
          mem[a0] <= din_q[15:8];
          mem[a1] <= din_q[7:0];
        end
        2'b10: begin
          mem[a0] <= din_q[31:24];
          mem[a1] <= din_q[23:16];
          mem[a2] <= din_q[15:8];
          mem[a3] <= din_q[7:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      size_q  <= 2'b00;
      rw_q    <= 1'b0;
      sext_q  <= 1'b0;
      din_q   <= 32'd0;
      dout_q  <= 32'd0;
      moc_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          moc_q <= 1'b0;
          if (MOV) begin
            addr_q  <= Address;
            size_q  <= size;
            rw_q    <= R_W;
            sext_q  <= sign_ext;
            din_q   <= DataIn;
            cnt_q   <= WAIT_INIT;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            fault_q <= ~legal;
            if (legal && rw_q) begin
              dout_q <= rdata;
            end
            moc_q   <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // MOV must drop before another request is accepted.
          if (!MOV) begin
            moc_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          moc_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign DataOut = dout_q;
  assign MOC     = moc_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_ram_wait_param.sv
// tb/tb_ram_wait_param.sv - directed-vector bench for ram_wait_param
//
// Purpose: drives two instances (ADDR_W=8/WAIT_STATES=2 and ADDR_W=10/WAIT_STATES=0)
// through directed requests and compares against hand-computed values.
// Ports: none (top-level bench).

module tb_ram_wait_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mov0, mov1;
  logic        r_w;
  logic [1:0]  size;
  logic        sext;
  logic [9:0]  addr;
  logic [31:0] din;
  logic [31:0] dout0, dout1;
  logic        moc0, moc1;
  logic        flt0, flt1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ram_wait_param #(.ADDR_W(8), .WAIT_STATES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .MOV(mov0), .R_W(r_w), .size(size),
    .sign_ext(sext), .Address(addr[7:0]), .DataIn(din),
    .DataOut(dout0), .MOC(moc0), .fault(flt0)
  );

  ram_wait_param #(.ADDR_W(10), .WAIT_STATES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .MOV(mov1), .R_W(r_w), .size(size),
    .sign_ext(sext), .Address(addr), .DataIn(din),
    .DataOut(dout1), .MOC(moc1), .fault(flt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic cur_moc(input int sel);
    return (sel == 0) ? moc0 : moc1;
  endfunction

  // One full handshake; lat counts edges from MOV capture to MOC seen high.
  task automatic op(input int sel, input logic rw, input logic [1:0] sz, input logic se,
                    input logic [9:0] a, input logic [31:0] d,
                    output logic [31:0] q, output logic f, output int lat);
    @(negedge clk);
    r_w = rw; size = sz; sext = se; addr = a; din = d;
    if (sel == 0) mov0 = 1'b1; else mov1 = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end while (!cur_moc(sel) && lat < 50);
    if (!cur_moc(sel)) check("moc_timeout", {31'd0, cur_moc(sel)}, 32'd1);
    q = (sel == 0) ? dout0 : dout1;
    f = (sel == 0) ? flt0 : flt1;
    mov0 = 1'b0;
    mov1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("moc_fall", {31'd0, cur_moc(sel)}, 32'd0);
  endtask

  initial begin
    logic [31:0] q;
    logic        f;
    int          lat;
    int          n;

    rst_n = 1'b0; mov0 = 1'b0; mov1 = 1'b0; r_w = 1'b0; size = 2'b00;
    sext = 1'b0; addr = '0; din = '0;
    @(negedge clk);
    check("rst_dout", dout0, 32'd0);
    check("rst_moc", {31'd0, moc0}, 32'd0);
    check("rst_fault", {31'd0, flt0}, 32'd0);
    rst_n = 1'b1;

    // Word write then big-endian reads
    op(0, 1'b0, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, q, f, lat);
    check("wr_lat_ws2", lat, 32'd4);
    check("wr_fault", {31'd0, f}, 32'd0);
    op(0, 1'b1, 2'b00, 1'b0, 10'h011, 32'h0, q, f, lat);
    check("rd_b11", q, 32'h000000AD);
    op(0, 1'b1, 2'b00, 1'b1, 10'h011, 32'h0, q, f, lat);
    check("rd_b11_sx", q, 32'hFFFFFFAD);
    op(0, 1'b1, 2'b01, 1'b0, 10'h012, 32'h0, q, f, lat);
    check("rd_h12", q, 32'h0000BEEF);
    op(0, 1'b1, 2'b01, 1'b1, 10'h012, 32'h0, q, f, lat);
    check("rd_h12_sx", q, 32'hFFFFBEEF);
    check("rd_h12_fault", {31'd0, f}, 32'd0);

    // Faults
    op(0, 1'b1, 2'b10, 1'b0, 10'h006, 32'h0, q, f, lat);
    check("mis_word_fault", {31'd0, f}, 32'd1);
    check("mis_word_dout", q, 32'hFFFFBEEF);
    op(0, 1'b1, 2'b11, 1'b0, 10'h010, 32'h0, q, f, lat);
    check("size11_fault", {31'd0, f}, 32'd1);
    check("size11_dout", q, 32'hFFFFBEEF);

    op(0, 1'b0, 2'b10, 1'b0, 10'h000, 32'hA0A1A2A3, q, f, lat);
    op(0, 1'b0, 2'b10, 1'b0, 10'h004, 32'hB0B1B2B3, q, f, lat);
    op(0, 1'b0, 2'b01, 1'b0, 10'h003, 32'h00001234, q, f, lat);
    check("mis_half_wr_fault", {31'd0, f}, 32'd1);
    op(0, 1'b1, 2'b00, 1'b0, 10'h003, 32'h0, q, f, lat);
    check("byte03_kept", q, 32'h000000A3);
    op(0, 1'b1, 2'b00, 1'b0, 10'h004, 32'h0, q, f, lat);
    check("byte04_kept", q, 32'h000000B0);

    // Byte and halfword writes
    op(0, 1'b0, 2'b00, 1'b0, 10'h013, 32'h0000007E, q, f, lat);
    op(0, 1'b1, 2'b10, 1'b0, 10'h010, 32'h0, q, f, lat);
    check("byte_wr_merge", q, 32'hDEADBE7E);
    op(0, 1'b0, 2'b01, 1'b0, 10'h010, 32'h00008001, q, f, lat);
    op(0, 1'b1, 2'b01, 1'b1, 10'h010, 32'h0, q, f, lat);
    check("half_wr_sx", q, 32'hFFFF8001);

    // MOV held after MOC with inputs changing during BUSY and DONE
    @(negedge clk);
    r_w = 1'b0; size = 2'b10; sext = 1'b0; addr = 10'h030; din = 32'h01020304; mov0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    din = 32'h55667788;
    addr = 10'h034;
    n = 0;
    while (!moc0 && n < 50) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("hold_moc_up", {31'd0, moc0}, 32'd1);
    din = 32'h99999999;
    addr = 10'h030;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("hold_moc_stays", {31'd0, moc0}, 32'd1);
    mov0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("hold_moc_drop", {31'd0, moc0}, 32'd0);
    op(0, 1'b1, 2'b10, 1'b0, 10'h030, 32'h0, q, f, lat);
    check("hold_single_wr", q, 32'h01020304);
    check("hold_next_lat", lat, 32'd4);

    // Reset during BUSY abandons the pending write
    op(0, 1'b0, 2'b10, 1'b0, 10'h020, 32'h11223344, q, f, lat);
    op(0, 1'b1, 2'b10, 1'b0, 10'h020, 32'h0, q, f, lat);
    check("pre_rst_rd", q, 32'h11223344);
    @(negedge clk);
    r_w = 1'b0; size = 2'b10; addr = 10'h020; din = 32'hCAFEF00D; mov0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midop_rst_moc", {31'd0, moc0}, 32'd0);
    check("midop_rst_dout", dout0, 32'd0);
    mov0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("no_resume_moc", {31'd0, moc0}, 32'd0);
    op(0, 1'b1, 2'b10, 1'b0, 10'h020, 32'h0, q, f, lat);
    check("abandoned_wr", q, 32'h11223344);

    // ADDR_W=10, WAIT_STATES=0 instance
    op(1, 1'b0, 2'b10, 1'b0, 10'h3FC, 32'hA5C30FF0, q, f, lat);
    check("ws0_lat", lat, 32'd2);
    op(1, 1'b1, 2'b10, 1'b0, 10'h3FC, 32'h0, q, f, lat);
    check("aw10_rd", q, 32'hA5C30FF0);
    check("aw10_fault", {31'd0, f}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_wait_param.md
# ram_wait_param

Parametrised, synchronous, byte-addressed data/instruction RAM for the ARM data path, successor to the asynchronous 256-byte MOV/MOC RAM. It keeps the big-endian byte/halfword/word access model and the MOV/MOC handshake with the control unit, and adds:

- clocked operation with a programmable number of wait states;
- configurable address width;
- sign-extending loads;
- alignment/illegal-size fault reporting.

It sits between the control unit's memory-request signals and the MAR/MDR registers.

## Interface
Parameters:
- ADDR_W, 8, address width; memory depth is 2**ADDR_W bytes
- WAIT_STATES, 2, extra cycles between request capture and access completion (0..15)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset; one clock domain only
- MOV  in  1  memory operation valid; request held by control unit until MOC seen
- R_W  in  1  1 = read, 0 = write
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- sign_ext  in  1  reads only: 1 = sign-extend byte/halfword into 32 bits
- Address  in  ADDR_W  byte address, big-endian (lowest address = MSB)
- DataIn  in  32  write data; byte uses [7:0], halfword uses [15:0]
- DataOut  out  32  read data, zero- or sign-extended
- MOC  out  1  memory operation complete
- fault  out  1  qualified by MOC; request was misaligned or size==11

## Operation
- FSM states and transitions:
  - IDLE: MOC=0. On an edge with MOV=1, latch Address, size, R_W, sign_ext and DataIn; load wait counter with WAIT_STATES; go to BUSY.
  - BUSY: on each edge with counter != 0, decrement the counter. On the edge with counter == 0, perform the access and go to DONE.
  - DONE: MOC=1. Stay while MOV=1. On an edge with MOV=0, go to IDLE (MOC=0).
- Alignment rules:
  - Halfword requires Address[0]==0.
  - Word requires Address[1:0]==00.
  - size==11 is always illegal.
  - On a violation: no memory write, DataOut unchanged, fault=1 in DONE. A legal access sets fault=0.
- Reads:
  - Bytes are assembled big-endian: word = {M[a],M[a+1],M[a+2],M[a+3]}; halfword = {M[a],M[a+1]}.
  - Bits above the access width are 0, or copies of the access MSB when sign_ext=1.
- Writes: store DataIn[31:24..7:0] big-endian into the addressed bytes. DataOut is unchanged by writes.
- Aligned accesses never cross the top of memory, so there is no wrap-around case.
- Inputs that change during BUSY/DONE are ignored; the latched copy is used.
- MOV held high after DONE does not start a second access. MOV must drop to 0 (DONE→IDLE) before a new request is accepted.

## Timing
- Reset values (asynchronous, immediate on rst_n=0): state IDLE, MOC=0, fault=0, DataOut=0, counter=0.
- Memory array is not cleared by reset; its contents are undefined until written or preloaded by the bench.
- Latency: MOV sampled high at edge N → access performed and MOC=1 after edge N+1+WAIT_STATES. With WAIT_STATES=0, MOC rises after edge N+1.
- DataOut and fault are valid in the same cycle MOC first rises, and are stable while MOC=1.
- MOC falls after the first edge at which MOV=0 is sampled in DONE.
- Minimum request-to-request spacing is WAIT_STATES+3 cycles.
- Reset mid-operation: a pending write whose access edge has not occurred is abandoned (memory unchanged). The FSM returns to IDLE and does not resume after reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Word write then reads, WAIT_STATES=2: write 0xDEADBEEF at 0x10, then:
  - byte read at 0x11, sign_ext=0 → DataOut=0x000000AD;
  - sign_ext=1 → 0xFFFFFFAD;
  - halfword read at 0x12 → 0x0000BEEF, sign-extended 0xFFFFBEEF.
- Latency: MOV rises before edge N → MOC=1 after edge N+3 and falls one edge after MOV=0. Repeat with WAIT_STATES=0 → MOC=1 after edge N+1.
- Faults:
  - halfword write of 0x1234 at 0x03 → MOC=1, fault=1, bytes 0x03/0x04 unchanged;
  - word read at 0x06 → fault=1, DataOut keeps its previous value;
  - size=11 → fault=1.
- Reset mid-op: start word write of 0xCAFEF00D at 0x20, assert rst_n=0 during BUSY → MOC=0, DataOut=0 immediately; memory at 0x20..0x23 unchanged.
- MOV held high for 10 cycles after MOC, with DataIn changed during BUSY → exactly one write, containing the originally latched value. The next request is accepted only after MOV drops.
- Run with ADDR_W=10: word write/read at 0x3FC → correct data, no fault.
